rev_cnt_disp: RTL and testbench

//   Display/monitor stage downstream of the 16-bit reversible counter.

---
 rtl/rev_cnt_pkg.sv | 34 +++
 rtl/hex7seg_dec.sv | 11 +
 rtl/rev_cnt_disp.sv | 125 ++++++++++++
 tb/tb_rev_cnt_disp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rev_cnt_pkg.sv
// Shared types and constants for the reversible-counter display stage.
package rev_cnt_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {BLANK, SCAN} state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    pat = 7'h7F;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg_dec
  import rev_cnt_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/rev_cnt_disp.sv
// 4-digit multiplexed hex display and wrap-event monitor for the reversible counter.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module rev_cnt_disp
  import rev_cnt_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cnt,
  input  logic              rc,
  input  logic              s,
  input  logic              wrap_clr,
  output logic [3:0]        an,
  output logic [7:0]        seg,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_flag
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [WRAP_W-1:0]  WRAP_MAX  = '1;

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [IDX_W-1:0]   idx;
  logic [15:0]        snap;
  state_t             state;
  logic [3:0]         nibble;
  logic [6:0]         dec_seg;
  logic               lead_blank;
  logic [3:0]         an_next;
  logic [7:0]         seg_next;

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n)
      presc <= '0;
    else if (tick)
      presc <= '0;
    else
      presc <= presc + PRESC_W'(1);
  end

  assign nibble = snap[{idx, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero.
  always_comb begin
    case (idx)
      2'd1:    lead_blank = (snap[15:4]  == 12'h000);
      2'd2:    lead_blank = (snap[15:8]  == 8'h00);
      2'd3:    lead_blank = (snap[15:12] == 4'h0);
      default: lead_blank = 1'b0;
    endcase
  end
`else
  assign lead_blank = 1'b0;
`endif

  always_comb begin
    an_next  = 4'hF;
    seg_next = SEG_BLANK;
    if (state == SCAN) begin
      an_next = ~(4'b0001 << idx);
      if (!lead_blank)
        seg_next = {~((idx == '0) && !s), dec_seg};
    end
  end

  // snap is reloaded only when the scan rolls back to digit 0, so a frame is coherent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
      idx   <= '0;
      snap  <= '0;
      an    <= 4'hF;
      seg   <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      case (state)
        BLANK: begin
          if (tick) begin
            snap  <= cnt;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (tick) begin
            idx <= idx + IDX_W'(1);
            if (idx == IDX_LAST)
              snap <= cnt;
          end
        end
      endcase
    end
  end

  // A clear coinciding with an event keeps that event, so the count restarts at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_cnt  <= '0;
      wrap_flag <= 1'b0;
    end else if (wrap_clr) begin
      wrap_cnt  <= WRAP_W'(rc);
      wrap_flag <= rc;
    end else if (rc) begin
      wrap_flag <= 1'b1;
      if (wrap_cnt != WRAP_MAX)
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end

endmodule

// File: tb/tb_rev_cnt_disp.sv
// Self-checking bench for rev_cnt_disp: directed literal checks plus a randomized run against a frame-level model.
module tb_rev_cnt_disp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cnt;
  logic        rc;
  logic        s;
  logic        wrap_clr;
  logic [3:0]  an, an_w2;
  logic [7:0]  seg, seg_w2;
  logic [7:0]  wrap_cnt;
  logic [1:0]  wrap_cnt_w2;
  logic        wrap_flag, wrap_flag_w2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rev_cnt_disp #(.SCAN_DIV(4), .WRAP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .rc(rc), .s(s), .wrap_clr(wrap_clr),
    .an(an), .seg(seg), .wrap_cnt(wrap_cnt), .wrap_flag(wrap_flag)
  );

  rev_cnt_disp #(.SCAN_DIV(4), .WRAP_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .rc(rc), .s(s), .wrap_clr(wrap_clr),
    .an(an_w2), .seg(seg_w2), .wrap_cnt(wrap_cnt_w2), .wrap_flag(wrap_flag_w2)
  );

  // Standard hex glyphs, active-low {g,f,e,d,c,b,a}.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: edges since reset, value shown in the current frame, wrap tallies.
  bit          model_valid = 0;
  int          edges = 0;
  logic [15:0] frame_val = '0;
  int          wc = 0, wc2 = 0;
  bit          wf = 0;
  logic [3:0]  exp_an = 4'hF;
  logic [7:0]  exp_seg = 8'hFF;

  // With SCAN_DIV=4 a slot lasts 4 edges; the first tick is edge 4 and frames repeat every 16 edges.
  function automatic logic [11:0] expected_display(int m, logic [15:0] v, logic s_in);
    int d;
    logic [15:0] upper;
    logic [3:0] nib;
    logic [7:0] sg;
    if (m < 4) return {4'hF, 8'hFF};
    d = ((m / 4) - 1) % 4;
    upper = v >> (4 * d);
    nib = upper[3:0];
    sg = {!(d == 0 && !s_in), glyph[nib]};
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0000) sg = 8'hFF;
`endif
    return {~(4'b0001 << d), sg};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      model_valid = 1;
      edges = 0;
      frame_val = '0;
      {exp_an, exp_seg} = {4'hF, 8'hFF};
      wc = 0; wc2 = 0; wf = 0;
    end else begin
      {exp_an, exp_seg} = expected_display(edges, frame_val, s);
      edges++;
      if (edges % 16 == 4) frame_val = cnt;
      if (wrap_clr) begin
        wc = int'(rc); wc2 = int'(rc); wf = rc;
      end else if (rc) begin
        wf = 1;
        if (wc < 255) wc++;
        if (wc2 < 3) wc2++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] c, input logic dir,
                               input logic w, input logic clr);
    rst_n = r; cnt = c; s = dir; rc = w; wrap_clr = clr;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("an", 32'(an), 32'(exp_an));
      checkOutput("seg", 32'(seg), 32'(exp_seg));
      checkOutput("an_w2", 32'(an_w2), 32'(exp_an));
      checkOutput("seg_w2", 32'(seg_w2), 32'(exp_seg));
      checkOutput("wrap_cnt", 32'(wrap_cnt), 32'(wc));
      checkOutput("wrap_flag", 32'(wrap_flag), 32'(wf));
      checkOutput("wrap_cnt_w2", 32'(wrap_cnt_w2), 32'(wc2));
      checkOutput("wrap_flag_w2", 32'(wrap_flag_w2), 32'(wf));
    end
  end

  initial begin
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    stepCycles(3);
    checkOutput("reset an", 32'(an), 32'h0F);
    checkOutput("reset seg", 32'(seg), 32'hFF);
    checkOutput("reset wrap_cnt", 32'(wrap_cnt), 32'h0);
    checkOutput("reset wrap_flag", 32'(wrap_flag), 32'h0);

    applyStimulus(1'b1, 16'h1A2F, 1'b1, 1'b0, 1'b0);
    stepCycles(6);
    checkOutput("digit0 an", 32'(an), 32'hE);
    checkOutput("digit0 seg", 32'(seg), 32'h8E);
    stepCycles(4);
    checkOutput("digit1 an", 32'(an), 32'hD);
    checkOutput("digit1 seg", 32'(seg), 32'hA4);
    cnt = 16'h0000;
    stepCycles(4);
    checkOutput("digit2 an", 32'(an), 32'hB);
    checkOutput("digit2 seg held", 32'(seg), 32'h88);
    stepCycles(4);
    checkOutput("digit3 an", 32'(an), 32'h7);
    checkOutput("digit3 seg held", 32'(seg), 32'hF9);
    stepCycles(4);
    checkOutput("new frame an", 32'(an), 32'hE);
    checkOutput("new frame seg", 32'(seg), 32'hC0);

    rc = 1'b1;
    stepCycles(3);
    rc = 1'b0;
    checkOutput("wrap x3 cnt", 32'(wrap_cnt), 32'd3);
    checkOutput("wrap x3 flag", 32'(wrap_flag), 32'd1);
    rc = 1'b1; wrap_clr = 1'b1;
    stepCycles(1);
    checkOutput("clr+event cnt", 32'(wrap_cnt), 32'd1);
    checkOutput("clr+event flag", 32'(wrap_flag), 32'd1);
    rc = 1'b0;
    stepCycles(1);
    checkOutput("clr cnt", 32'(wrap_cnt), 32'd0);
    checkOutput("clr flag", 32'(wrap_flag), 32'd0);
    wrap_clr = 1'b0; rc = 1'b1;
    stepCycles(5);
    rc = 1'b0;
    stepCycles(2);
    checkOutput("sat w2 cnt", 32'(wrap_cnt_w2), 32'd3);
    checkOutput("no sat w8 cnt", 32'(wrap_cnt), 32'd5);

    applyStimulus(1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
    stepCycles(2);
    checkOutput("mid reset an", 32'(an), 32'h0F);
    checkOutput("mid reset seg", 32'(seg), 32'hFF);
    checkOutput("mid reset wrap_cnt", 32'(wrap_cnt), 32'h0);
    rst_n = 1'b1;
    stepCycles(6);
    checkOutput("down digit0 seg", 32'(seg), 32'h12);
    stepCycles(4);
    checkOutput("down digit1 an", 32'(an), 32'hD);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("down digit1 seg", 32'(seg), 32'hFF);
`else
    checkOutput("down digit1 seg", 32'(seg), 32'hC0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) cnt = 16'($urandom);
      if ($urandom_range(0, 9) == 0) s = ~s;
      rc = ($urandom_range(0, 7) == 0);
      wrap_clr = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
      stepCycles(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
